// File: rtl/master_rd_arbiter.sv
// Round-robin arbiter sharing one master read port between NUM_REQ requesters.
// One outstanding read at a time; a WAIT timeout keeps a dead slave from hanging the port.
module master_rd_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 256
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_rd,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_gnt,
  output logic [DATA_W-1:0]         req_data_out,
  output logic [NUM_REQ-1:0]        req_data_val,
  output logic [NUM_REQ-1:0]        req_err,
  output logic [ADDR_W-1:0]         master_addr,
  output logic                      master_rd,
  input  logic [DATA_W-1:0]         master_data_in,
  input  logic                      master_data_in_val,
  output logic                      busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  logic [1:0]    state;
  logic [IW-1:0] last;
  logic [IW-1:0] win;
  logic [IW-1:0] pick;
  logic [IW-1:0] cand;
  logic          found;
  logic [15:0]   cnt;

  // Scan upward from the slot after the last winner, wrapping, and take the first requester found.
  always_comb begin
    pick  = last;
    cand  = last;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(last) + k) % NUM_REQ);
      if (!found && req_rd[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      last         <= IW'(NUM_REQ - 1);
      win          <= '0;
      cnt          <= '0;
      req_gnt      <= '0;
      req_data_out <= '0;
      req_data_val <= '0;
      req_err      <= '0;
      master_addr  <= '0;
      master_rd    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      req_data_val <= '0;
      req_err      <= '0;
      case (state)
        S_IDLE: begin
          if (|req_rd) begin
            state       <= S_ISSUE;
            win         <= pick;
            req_gnt     <= NUM_REQ'(1) << pick;
            master_addr <= req_addr[pick*ADDR_W +: ADDR_W];
            master_rd   <= 1'b1;
            busy        <= 1'b1;
          end
        end
        S_ISSUE: begin
          master_rd <= 1'b0;
          cnt       <= '0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          // A response on the timeout edge takes precedence over the error.
          if (master_data_in_val) begin
            req_data_out <= master_data_in;
            req_data_val <= NUM_REQ'(1) << win;
            req_gnt      <= '0;
            busy         <= 1'b0;
            last         <= win;
            state        <= S_IDLE;
          end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
            req_err <= NUM_REQ'(1) << win;
            req_gnt <= '0;
            busy    <= 1'b0;
            last    <= win;
            state   <= S_IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state   <= S_IDLE;
          req_gnt <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_master_rd_arbiter.sv
// Directed bench for master_rd_arbiter: a table of read transactions with hand-computed
// grants/addresses/data, plus hand sequences for timeout, async reset and early request drop.
module tb_master_rd_arbiter;

  logic         clk;
  logic         reset;
  logic [3:0]   req_rd;
  logic [255:0] req_addr;
  logic [3:0]   req_gnt;
  logic [63:0]  req_data_out;
  logic [3:0]   req_data_val;
  logic [3:0]   req_err;
  logic [63:0]  master_addr;
  logic         master_rd;
  logic [63:0]  master_data_in;
  logic         master_data_in_val;
  logic         busy;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [63:0] last_data;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [63:0] tag;
    logic [3:0]  gnt;
    logic [63:0] addr;
    int          dly;
    logic [63:0] data;
  } vec_t;

  vec_t vecs[15];

  master_rd_arbiter #(
    .NUM_REQ(4),
    .ADDR_W (64),
    .DATA_W (64),
    .TIMEOUT(8)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .req_rd            (req_rd),
    .req_addr          (req_addr),
    .req_gnt           (req_gnt),
    .req_data_out      (req_data_out),
    .req_data_val      (req_data_val),
    .req_err           (req_err),
    .master_addr       (master_addr),
    .master_rd         (master_rd),
    .master_data_in    (master_data_in),
    .master_data_in_val(master_data_in_val),
    .busy              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_gnt"}, 64'(req_gnt), 64'h0);
    check_output({tag, "_val"}, 64'(req_data_val), 64'h0);
    check_output({tag, "_err"}, 64'(req_err), 64'h0);
    check_output({tag, "_rd"}, 64'(master_rd), 64'h0);
    check_output({tag, "_addr"}, master_addr, 64'h0);
    check_output({tag, "_dout"}, req_data_out, 64'h0);
    check_output({tag, "_busy"}, 64'(busy), 64'h0);
  endtask

  task automatic do_reset();
    req_rd = '0;
    master_data_in_val = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check_all_zero("reset");
    reset = 1'b0;
    last_data = '0;
    @(posedge clk); #1;
  endtask

  // Runs one full read; entered and left one time unit after a rising edge, DUT in IDLE.
  task automatic apply_stimulus(input vec_t v, input bit drop_early);
    for (int i = 0; i < 4; i++) req_addr[i*64 +: 64] = v.tag + 64'(i);
    req_rd = v.req;
    @(posedge clk); #1;
    check_output("issue_rd", 64'(master_rd), 64'h1);
    check_output("issue_gnt", 64'(req_gnt), 64'(v.gnt));
    check_output("issue_addr", master_addr, v.addr);
    check_output("issue_busy", 64'(busy), 64'h1);
    if (drop_early) req_rd = '0;
    req_addr = {4{64'hBAD0_BAD0_BAD0_BAD0}};
    for (int c = 0; c < v.dly; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        check_output("wait_rd", 64'(master_rd), 64'h0);
        check_output("wait_gnt", 64'(req_gnt), 64'(v.gnt));
        check_output("wait_addr_hold", master_addr, v.addr);
      end
    end
    master_data_in = v.data;
    master_data_in_val = 1'b1;
    @(posedge clk); #1;
    master_data_in_val = 1'b0;
    req_rd = '0;
    check_output("done_val", 64'(req_data_val), 64'(v.gnt));
    check_output("done_data", req_data_out, v.data);
    check_output("done_err", 64'(req_err), 64'h0);
    check_output("done_gnt", 64'(req_gnt), 64'h0);
    check_output("done_busy", 64'(busy), 64'h0);
    last_data = v.data;
    @(posedge clk); #1;
    check_output("after_val", 64'(req_data_val), 64'h0);
    check_output("after_busy", 64'(busy), 64'h0);
  endtask

  initial begin
    vec_t v;
    reset = 1'b1;
    req_rd = '0;
    req_addr = '0;
    master_data_in = '0;
    master_data_in_val = 1'b0;
    last_data = '0;

    vecs[0]  = '{1'b1, 4'b0100, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0100, 64'h1,    3, 64'h1234_5678_9ABC_DEC0};
    vecs[1]  = '{1'b0, 4'b1111, 64'h1000, 4'b1000, 64'h1003, 1, 64'h11};
    vecs[2]  = '{1'b0, 4'b1111, 64'h2000, 4'b0001, 64'h2000, 1, 64'h22};
    vecs[3]  = '{1'b0, 4'b1111, 64'h3000, 4'b0010, 64'h3001, 1, 64'h33};
    vecs[4]  = '{1'b0, 4'b1111, 64'h4000, 4'b0100, 64'h4002, 1, 64'h44};
    vecs[5]  = '{1'b0, 4'b1111, 64'h5000, 4'b1000, 64'h5003, 1, 64'h55};
    vecs[6]  = '{1'b0, 4'b1111, 64'h6000, 4'b0001, 64'h6000, 2, 64'h66};
    vecs[7]  = '{1'b1, 4'b1010, 64'h7000, 4'b0010, 64'h7001, 1, 64'h77};
    vecs[8]  = '{1'b0, 4'b1010, 64'h8000, 4'b1000, 64'h8003, 1, 64'h88};
    vecs[9]  = '{1'b0, 4'b0010, 64'h9000, 4'b0010, 64'h9001, 1, 64'h99};
    vecs[10] = '{1'b0, 4'b1010, 64'hA000, 4'b1000, 64'hA003, 1, 64'hAA};
    vecs[11] = '{1'b0, 4'b0110, 64'hB000, 4'b0010, 64'hB001, 1, 64'hBB};
    vecs[12] = '{1'b0, 4'b0101, 64'hC000, 4'b0100, 64'hC002, 1, 64'hCC};
    vecs[13] = '{1'b0, 4'b0011, 64'hD000, 4'b0001, 64'hD000, 1, 64'hDD};
    // Response lands on the same edge the timeout would fire: data must win.
    vecs[14] = '{1'b0, 4'b1000, 64'hE000, 4'b1000, 64'hE003, 8, 64'hEE};

    #2;
    check_all_zero("por");

    for (int k = 0; k < 15; k++) begin
      if (vecs[k].rst) do_reset();
      apply_stimulus(vecs[k], 1'b0);
    end

    // Silent slave on requester 0 (last winner is 3).
    for (int i = 0; i < 4; i++) req_addr[i*64 +: 64] = 64'h5100 + 64'(i);
    req_rd = 4'b0001;
    @(posedge clk); #1;
    check_output("to_issue_gnt", 64'(req_gnt), 64'h1);
    check_output("to_issue_addr", master_addr, 64'h5100);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      check_output("to_wait_err", 64'(req_err), 64'h0);
      check_output("to_wait_busy", 64'(busy), 64'h1);
    end
    @(posedge clk); #1;
    req_rd = '0;
    check_output("to_err", 64'(req_err), 64'h1);
    check_output("to_noval", 64'(req_data_val), 64'h0);
    check_output("to_busy", 64'(busy), 64'h0);
    check_output("to_gnt", 64'(req_gnt), 64'h0);
    check_output("to_dout", req_data_out, last_data);
    master_data_in = 64'hDEAD_BEEF_0000_0001;
    master_data_in_val = 1'b1;
    @(posedge clk); #1;
    master_data_in_val = 1'b0;
    check_output("late_err", 64'(req_err), 64'h0);
    check_output("late_val", 64'(req_data_val), 64'h0);
    check_output("late_dout", req_data_out, last_data);
    check_output("late_busy", 64'(busy), 64'h0);

    // Async reset in the middle of a WAIT for requester 3 (last winner is 0).
    for (int i = 0; i < 4; i++) req_addr[i*64 +: 64] = 64'h6200 + 64'(i);
    req_rd = 4'b1000;
    @(posedge clk); #1;
    check_output("rw_issue_gnt", 64'(req_gnt), 64'h8);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_output("rw_wait_gnt", 64'(req_gnt), 64'h8);
    #2 reset = 1'b1;
    #1;
    check_all_zero("async_rst");
    req_rd = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    last_data = '0;
    master_data_in = 64'h5A5A_5A5A_5A5A_5A5A;
    master_data_in_val = 1'b1;
    @(posedge clk); #1;
    master_data_in_val = 1'b0;
    check_output("stale_val", 64'(req_data_val), 64'h0);
    check_output("stale_dout", req_data_out, 64'h0);
    check_output("stale_busy", 64'(busy), 64'h0);

    v = '{1'b0, 4'b1000, 64'hF000, 4'b1000, 64'hF003, 2, 64'hF3};
    apply_stimulus(v, 1'b0);
    v = '{1'b0, 4'b1001, 64'h0100, 4'b0001, 64'h0100, 1, 64'hF4};
    apply_stimulus(v, 1'b0);
    v = '{1'b0, 4'b0010, 64'h0200, 4'b0010, 64'h0201, 2, 64'hF5F5_0000_1111_2222};
    apply_stimulus(v, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
